// File: rtl/led_pkg.sv
// Shared encodings and level constants for the LED bar pattern blocks.
package led_pkg;
  localparam int LEVEL_W = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;

  typedef enum logic [1:0] {
    MODE_BOUNCE  = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_FILL    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;
endpackage

// File: rtl/led_step_timer.sv
// Step prescaler: counts 0..TICKS-1, freezes while paused, flags the last tick as a step boundary.
module led_step_timer #(
  parameter int TICKS = 6_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  output logic boundary
);
  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!pause) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  assign boundary = !pause && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bar pattern sequencer: steps one of four effects and registers per-LED levels for the PWM stage.
// mode    | meaning
// BOUNCE  | bright spot walks back and forth with a decaying halo
// CHASE   | spot walks forward with a dim tail, wrapping
// FILL    | bar fills from LED0 up to all lit, then clears
// BREATHE | all LEDs ramp up and down together
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int N_LEDS      = 10,
  parameter int STEP_TICKS  = 6_000_000,
  parameter int MIN_BRIGHT  = 8,
  parameter int BREATHE_INC = 8
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      mode_next,
  input  logic                      pause,
  output logic [N_LEDS*LEVEL_W-1:0] brightness,
  output logic [1:0]                mode,
  output logic                      step_strobe
);
  localparam int PW = $clog2(N_LEDS + 1);

  mode_e                     mode_q, mode_d;
  dir_e                      dir_q, dir_d;
  logic [PW-1:0]             pos_q, pos_d;
  logic [LEVEL_W-1:0]        level_q, level_d;
  logic                      pending_q, pending_d;
  logic                      step_strobe_q, step_strobe_d;
  logic [N_LEDS*LEVEL_W-1:0] brightness_q, brightness_d;
  logic                      boundary;

  led_step_timer #(.TICKS(STEP_TICKS)) u_timer (
    .clk      (CLOCK_50),
    .reset    (reset),
    .pause    (pause),
    .boundary (boundary)
  );

  function automatic logic [N_LEDS*LEVEL_W-1:0] map_levels(
    input mode_e m, input logic [PW-1:0] p, input logic [LEVEL_W-1:0] lvl);
    logic [N_LEDS*LEVEL_W-1:0] r;
    int pi, prev, d, v;
    r    = '0;
    pi   = int'(p);
    prev = (pi == 0) ? N_LEDS - 1 : pi - 1;
    for (int i = 0; i < N_LEDS; i++) begin
      v = 0;
      d = 0;
      unique case (m)
        MODE_BOUNCE: begin
          d = (i > pi) ? i - pi : pi - i;
          if (d == 0)      v = int'(LEVEL_MAX);
          else if (d >= 8) v = MIN_BRIGHT;
          else             v = MIN_BRIGHT + (int'(LEVEL_MAX) >> d);
          if (v > int'(LEVEL_MAX)) v = int'(LEVEL_MAX);
        end
        MODE_CHASE: begin
          if (i == pi)        v = int'(LEVEL_MAX);
          else if (i == prev) v = 64;
        end
        MODE_FILL:    v = (i < pi) ? int'(LEVEL_MAX) : 0;
        MODE_BREATHE: v = int'(lvl);
      endcase
      r[i*LEVEL_W +: LEVEL_W] = LEVEL_W'(v);
    end
    return r;
  endfunction

  always_comb begin
    mode_d        = mode_q;
    dir_d         = dir_q;
    pos_d         = pos_q;
    level_d       = level_q;
    pending_d     = pending_q | mode_next;
    step_strobe_d = boundary;
    brightness_d  = map_levels(mode_q, pos_q, level_q);
    if (boundary) begin
      pending_d = 1'b0;
      // A request arriving on the boundary cycle itself still counts for this step.
      if (pending_q || mode_next) begin
        mode_d  = mode_e'(mode_q + 2'd1);
        pos_d   = '0;
        dir_d   = DIR_UP;
        level_d = '0;
      end else begin
        unique case (mode_q)
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (pos_q == PW'(N_LEDS - 1)) begin
                pos_d = PW'(N_LEDS - 2);
                dir_d = DIR_DOWN;
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = PW'(1);
                dir_d = DIR_UP;
              end else begin
                pos_d = pos_q - PW'(1);
              end
            end
          end
          MODE_CHASE: pos_d = (pos_q == PW'(N_LEDS - 1)) ? '0 : pos_q + PW'(1);
          MODE_FILL:  pos_d = (pos_q == PW'(N_LEDS)) ? '0 : pos_q + PW'(1);
          MODE_BREATHE: begin
            if (dir_q == DIR_UP) begin
              if (int'(level_q) > int'(LEVEL_MAX) - BREATHE_INC) begin
                level_d = LEVEL_MAX;
                dir_d   = DIR_DOWN;
              end else begin
                level_d = level_q + LEVEL_W'(BREATHE_INC);
              end
            end else begin
              if (int'(level_q) < BREATHE_INC) begin
                level_d = '0;
                dir_d   = DIR_UP;
              end else begin
                level_d = level_q - LEVEL_W'(BREATHE_INC);
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mode_q        <= MODE_BOUNCE;
      dir_q         <= DIR_UP;
      pos_q         <= '0;
      level_q       <= '0;
      pending_q     <= 1'b0;
      step_strobe_q <= 1'b0;
      brightness_q  <= '0;
    end else begin
      mode_q        <= mode_d;
      dir_q         <= dir_d;
      pos_q         <= pos_d;
      level_q       <= level_d;
      pending_q     <= pending_d;
      step_strobe_q <= step_strobe_d;
      brightness_q  <= brightness_d;
    end
  end

  assign brightness  = brightness_q;
  assign mode        = mode_q;
  assign step_strobe = step_strobe_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a queue of expected per-step results.
module tb_led_pattern_sequencer;
  localparam int NL = 10;
  localparam int BW = NL * 8;

  logic          CLOCK_50;
  logic          reset;
  logic          mode_next;
  logic          pause;
  logic [BW-1:0] brightness;
  logic [1:0]    mode;
  logic          step_strobe;

  typedef struct packed {
    logic [1:0]    mode;
    logic [BW-1:0] bright;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   last_strobe = 0;
  int   bounce_lvl [8] = '{255, 135, 71, 39, 23, 15, 11, 9};

  led_pattern_sequencer #(
    .N_LEDS(NL), .STEP_TICKS(4), .MIN_BRIGHT(8), .BREATHE_INC(8)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .mode_next   (mode_next),
    .pause       (pause),
    .brightness  (brightness),
    .mode        (mode),
    .step_strobe (step_strobe)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [BW-1:0] pat_bounce(input int p);
    logic [BW-1:0] r;
    int d;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      d = (i > p) ? i - p : p - i;
      r[i*8 +: 8] = (d < 8) ? 8'(bounce_lvl[d]) : 8'd8;
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] pat_chase(input int p);
    logic [BW-1:0] r;
    r = '0;
    r[((p + NL - 1) % NL)*8 +: 8] = 8'd64;
    r[p*8 +: 8] = 8'd255;
    return r;
  endfunction

  function automatic logic [BW-1:0] pat_fill(input int p);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < p; i++) r[i*8 +: 8] = 8'd255;
    return r;
  endfunction

  function automatic logic [BW-1:0] pat_all(input int l);
    logic [BW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*8 +: 8] = 8'(l);
    return r;
  endfunction

  function automatic int bounce_pos(input int k);
    int m;
    m = k % (2 * (NL - 1));
    return (m < NL) ? m : 2 * (NL - 1) - m;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Waits for the next strobe, then pops and checks mode now and brightness one cycle later.
  task automatic step_chk(input string tag, input int gap);
    exp_t e;
    int n;
    n = 0;
    while (step_strobe !== 1'b1 && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk({tag, "_strobe"}, step_strobe, 1'b1);
    if (gap > 0) chk({tag, "_gap"}, cyc - last_strobe, gap);
    last_strobe = cyc;
    e = sb.pop_front();
    chk({tag, "_mode"}, mode, e.mode);
    @(negedge CLOCK_50);
    chk({tag, "_bright"}, brightness, e.bright);
  endtask

  task automatic expect_step(input logic [1:0] m, input logic [BW-1:0] b,
                             input string tag, input int gap);
    exp_t e;
    e.mode   = m;
    e.bright = b;
    sb.push_back(e);
    step_chk(tag, gap);
  endtask

  initial begin
    int strobes;
    bit held;
    reset = 1'b1;
    mode_next = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_bright", brightness, '0);
    chk("rst_mode", mode, 2'd0);
    chk("rst_strobe", step_strobe, 1'b0);

    reset = 1'b0;
    last_strobe = cyc;
    @(negedge CLOCK_50);
    chk("post_rst_bright", brightness, pat_bounce(0));

    for (int k = 1; k <= 40; k++) expect_step(2'd0, pat_bounce(bounce_pos(k)), "bounce", 4);

    mode_next = 1'b1;
    @(negedge CLOCK_50);
    mode_next = 1'b0;
    expect_step(2'd1, pat_chase(0), "chase0", 4);
    expect_step(2'd1, pat_chase(1), "chase1", 4);

    pause = 1'b1;
    repeat (3) begin
      @(negedge CLOCK_50);
      mode_next = 1'b1;
      @(negedge CLOCK_50);
      mode_next = 1'b0;
    end
    pause = 1'b0;
    expect_step(2'd2, pat_fill(0), "multi_pulse", 0);
    for (int p = 1; p <= NL; p++) expect_step(2'd2, pat_fill(p), "fill", 4);
    expect_step(2'd2, pat_fill(0), "fill_wrap", 4);

    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    mode_next = 1'b1;
    @(negedge CLOCK_50);
    mode_next = 1'b0;
    expect_step(2'd3, pat_all(0), "coincident", 4);

    for (int k = 1; k <= 31; k++) expect_step(2'd3, pat_all(8 * k), "breathe_up", 4);
    expect_step(2'd3, pat_all(255), "breathe_top", 4);
    for (int k = 0; k <= 30; k++) expect_step(2'd3, pat_all(247 - 8 * k), "breathe_dn", 4);
    expect_step(2'd3, pat_all(0), "breathe_bot", 4);
    expect_step(2'd3, pat_all(8), "breathe_again", 4);

    pause = 1'b1;
    strobes = 0;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (step_strobe === 1'b1) strobes++;
      if (brightness !== pat_all(8)) held = 1'b0;
      mode_next = (i == 5);
    end
    chk("pause_strobes", strobes, 0);
    chk("pause_held", held, 1'b1);
    chk("pause_mode", mode, 2'd3);

    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("midpause_rst_bright", brightness, '0);
    chk("midpause_rst_mode", mode, 2'd0);
    chk("midpause_rst_strobe", step_strobe, 1'b0);
    reset = 1'b0;
    pause = 1'b0;
    last_strobe = cyc;
    @(negedge CLOCK_50);
    chk("rerun_bright", brightness, pat_bounce(0));
    expect_step(2'd0, pat_bounce(1), "rerun_step", 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Pattern controller for the board LED bar: sequences and configures the per-LED 8-bit brightness levels that feed the downstream PWM comparators. Four selectable effects: bounce, chase, fill, breathe. Step rate comes from an internal prescaler. The block runs on the 50 MHz board clock, sits between the user inputs (keys/switches) and the PWM stage, and never drives LEDs directly.

## Interface
- `N_LEDS`, 10, number of LED channels (2..16)
- `STEP_TICKS`, 6_000_000, clock cycles per pattern step (≥2)
- `MIN_BRIGHT`, 8, floor level for bounce mode
- `BREATHE_INC`, 8, level increment per step in breathe mode (1..128)

- `CLOCK_50` in 1: system clock; all logic on the rising edge
- `reset` in 1: synchronous, active-high reset
- `mode_next` in 1: single-cycle pulse; requests advance to the next mode
- `pause` in 1: level; while high, the step prescaler freezes
- `brightness` out N_LEDS*8: packed levels; LED i at [8i+7:8i]; registered
- `mode` out 2: current mode; 0 = BOUNCE, 1 = CHASE, 2 = FILL, 3 = BREATHE
- `step_strobe` out 1: one-cycle pulse on each step boundary

## Operation
- State: `mode`, `pos` (0..N_LEDS), `dir` (up/down), `level` (8 bit), `pending` flag, prescaler count.
- Prescaler counts 0..STEP_TICKS-1 and wraps. A step boundary occurs when count == STEP_TICKS-1 and `pause`=0.
- `mode_next` sets `pending`.
  - Multiple pulses before a boundary collapse into one advance.
  - A pulse in the same cycle as a boundary is applied at that boundary.
- Step boundary with `pending`=1:
  - `mode` ← mode+1 (3 wraps to 0).
  - `pos` ← 0, `dir` ← up, `level` ← 0, `pending` ← 0.
  - No pattern advance on this step.
- Step boundary with `pending`=0 advances the pattern:
  - BOUNCE: up: pos+1; at pos==N_LEDS-1 → pos=N_LEDS-2, dir=down. Down mirrors this at pos==0 → pos=1, dir=up. Sequence 0,1..9,8..0,1…
  - CHASE: pos ← (pos+1) mod N_LEDS.
  - FILL: pos ← pos+1; at pos==N_LEDS → 0.
  - BREATHE, dir up: level+BREATHE_INC. If level > 255-BREATHE_INC → level=255, dir=down.
  - BREATHE, dir down: level-BREATHE_INC. If level < BREATHE_INC → level=0, dir=up.
- Brightness mapping per LED i:
  - BOUNCE: d=|i-pos|. d==0 → 255; d≥8 → MIN_BRIGHT; otherwise MIN_BRIGHT+(255>>d), saturated at 255.
  - CHASE: i==pos → 255; i==(pos-1) mod N_LEDS → 64; otherwise 0.
  - FILL: i<pos → 255; otherwise 0.
  - BREATHE: all LEDs = level.
- `pause` holds the prescaler and suppresses `step_strobe`. `mode_next` is still latched while paused.

## Timing
- Reset (synchronous) clears `brightness` to all 0, `mode` to 0, `step_strobe` to 0, and `pos`, `level`, `pending` and the prescaler count to 0. `dir` resets to up.
- First cycle after reset release: brightness shows BOUNCE with pos=0, i.e. LED0=255, LED1=135, LED2=71.
- `step_strobe` is asserted in the cycle after the boundary edge, coincident with the new state.
- `brightness` lags state by exactly 1 cycle: registered from the updated state.
- Reset asserted mid-step or mid-mode discards `pending` and the prescaler count.
- `mode` output updates in the same cycle as `step_strobe`.

## Structure
- Shared package `led_pkg`:
  - mode encodings MODE_BOUNCE/CHASE/FILL/BREATHE
  - DIR_UP/DIR_DOWN
  - the LEVEL_MAX=255 constant
  - the 8-bit level width
- One sub-module, `led_step_timer`: parameterised prescaler with `pause` input and boundary pulse output. It is reused by later LED blocks.
- The brightness mapping is a combinational function feeding the output register, inside the top module.

## Test plan
Benches use STEP_TICKS=4, N_LEDS=10.
- Reset then run 40 steps → pos follows 0,1..9,8..0,1; `step_strobe` every 4 cycles; LED at pos=255, neighbour=135.
- `mode_next` pulse mid-step → `mode`=1 at the next strobe; brightness LED0=255, LED9=64, others 0; following step LED1=255, LED0=64.
- Three `mode_next` pulses within one step → mode advances by exactly 1.
- `mode_next` coincident with a boundary → applied at that boundary.
- FILL for 11 steps → LEDs lit 0..10 count, then all 0.
- BREATHE with INC=8 → level 0,8..248,255,247..7,0; `pause` high for 20 cycles → no strobe and level held; reset mid-pause → all outputs 0 next cycle.
